stim_resp_sequencer: RTL and testbench



---
 rtl/stim_resp_sequencer.sv | 146 ++++++++++++++
 tb/tb_stim_resp_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stim_resp_sequencer.sv
// Exhaustive stimulus/response sequencer for a small combinational circuit under test.
// Drives every pattern on N in ascending order. After each pattern it waits SETTLE_CYCLES
// clocks, samples dut_out, and offers the (pattern, response) record on a valid/ready
// interface. Accepted responses are compacted into a 16-bit MISR signature.
//
// Ports:
//   CK            clock, rising edge
//   reset         asynchronous active-high reset
//   start         begin a sweep (acted on only in IDLE or DONE)
//   dut_out       response from the circuit under test
//   N             stimulus driven to the circuit under test
//   busy          sweep in progress
//   rec_valid     record available
//   rec_ready     downstream accepts the record
//   rec_pattern   stimulus belonging to the record
//   rec_response  sampled response belonging to the record
//   done          sweep complete (level)
//   signature     MISR value, stable while done is high
module stim_resp_sequencer #(
  parameter int unsigned N_WIDTH       = 1,
  parameter int unsigned OUT_WIDTH     = 1,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic [N_WIDTH-1:0]   N,
  output logic                 busy,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_pattern,
  output logic [OUT_WIDTH-1:0] rec_response,
  output logic                 done,
  output logic [15:0]          signature
);

  localparam logic [7:0]         CntReload = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_WIDTH-1:0] NOne      = 1;

  typedef enum logic [1:0] {StIdle, StSettle, StEmit, StDone} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [N_WIDTH-1:0]     n_q, n_d;
  logic                   busy_q, busy_d;
  logic                   rec_valid_q, rec_valid_d;
  logic [N_WIDTH-1:0]     rec_pattern_q, rec_pattern_d;
  logic [OUT_WIDTH-1:0]   rec_response_q, rec_response_d;
  logic                   done_q, done_d;
  logic [15:0]            sig_q, sig_d;
  logic [15:0]            resp_ext;
  logic                   fb;

  assign resp_ext = 16'(rec_response_q);
  assign fb       = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];

  // State and datapath registers
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      n_q            <= '0;
      busy_q         <= 1'b0;
      rec_valid_q    <= 1'b0;
      rec_pattern_q  <= '0;
      rec_response_q <= '0;
      done_q         <= 1'b0;
      sig_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      n_q            <= n_d;
      busy_q         <= busy_d;
      rec_valid_q    <= rec_valid_d;
      rec_pattern_q  <= rec_pattern_d;
      rec_response_q <= rec_response_d;
      done_q         <= done_d;
      sig_q          <= sig_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    n_d            = n_q;
    busy_d         = busy_q;
    rec_valid_d    = rec_valid_q;
    rec_pattern_d  = rec_pattern_q;
    rec_response_d = rec_response_q;
    done_d         = done_q;
    sig_d          = sig_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          n_d     = '0;
          sig_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CntReload;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          rec_response_d = dut_out;
          rec_pattern_d  = n_q;
          rec_valid_d    = 1'b1;
          state_d        = StEmit;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StEmit: begin
        // rec_valid is always high in this state, so ready alone completes the handshake
        if (rec_ready) begin
          rec_valid_d = 1'b0;
          sig_d       = {sig_q[14:0], fb} ^ resp_ext;
          if (&n_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            n_d     = n_q + NOne;
            cnt_d   = CntReload;
            state_d = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs come straight from registers
  always_comb begin
    N            = n_q;
    busy         = busy_q;
    rec_valid    = rec_valid_q;
    rec_pattern  = rec_pattern_q;
    rec_response = rec_response_q;
    done         = done_q;
    signature    = sig_q;
  end

endmodule

// File: tb/tb_stim_resp_sequencer.sv
module tb_stim_resp_sequencer;

  logic        CK = 1'b0;
  logic        reset;

  // Instance A: N_WIDTH=1, SETTLE_CYCLES=1, buffer or inverter DUT
  logic        start_a, ready_a, inv_a;
  logic        n_a, busy_a, valid_a, pat_a, resp_a, done_a, dout_a;
  logic [15:0] sig_a;

  // Instance B: N_WIDTH=2, SETTLE_CYCLES=3, buffer DUT
  logic        start_b, ready_b;
  logic [1:0]  n_b, pat_b, resp_b;
  logic        busy_b, valid_b, done_b;
  logic [15:0] sig_b;

  int vectors = 0;
  int miscompares = 0;

  assign dout_a = inv_a ? ~n_a : n_a;

  always #5 CK = ~CK;

  stim_resp_sequencer #(.N_WIDTH(1), .OUT_WIDTH(1), .SETTLE_CYCLES(1)) u_a (
    .CK(CK), .reset(reset), .start(start_a), .dut_out(dout_a), .N(n_a), .busy(busy_a),
    .rec_valid(valid_a), .rec_ready(ready_a), .rec_pattern(pat_a), .rec_response(resp_a),
    .done(done_a), .signature(sig_a)
  );

  stim_resp_sequencer #(.N_WIDTH(2), .OUT_WIDTH(2), .SETTLE_CYCLES(3)) u_b (
    .CK(CK), .reset(reset), .start(start_b), .dut_out(n_b), .N(n_b), .busy(busy_b),
    .rec_valid(valid_b), .rec_ready(ready_b), .rec_pattern(pat_b), .rec_response(resp_b),
    .done(done_b), .signature(sig_b)
  );

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start_a = 0; ready_a = 1; inv_a = 0; start_b = 0; ready_b = 1;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_n", 32'(n_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_pat", 32'(pat_a), 0);
    check("rst_resp", 32'(resp_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_sig", 32'(sig_a), 0);

    // Buffer sweep, N_WIDTH=1, SETTLE=1
    start_a = 1; step(); start_a = 0;
    check("buf_busy", 32'(busy_a), 1);
    check("buf_valid0_lo", 32'(valid_a), 0);
    step();
    check("buf_r0_valid", 32'(valid_a), 1);
    check("buf_r0_pat", 32'(pat_a), 0);
    check("buf_r0_resp", 32'(resp_a), 0);
    step();
    check("buf_n1", 32'(n_a), 1);
    check("buf_sig_mid", 32'(sig_a), 0);
    step();
    check("buf_r1_valid", 32'(valid_a), 1);
    check("buf_r1_pat", 32'(pat_a), 1);
    check("buf_r1_resp", 32'(resp_a), 1);
    check("buf_done_pre", 32'(done_a), 0);
    step();
    check("buf_done", 32'(done_a), 1);
    check("buf_busy_end", 32'(busy_a), 0);
    check("buf_sig", 32'(sig_a), 16'h0001);
    check("buf_n_hold", 32'(n_a), 1);

    // Inverter sweep, started from DONE; a start pulse mid-sweep must be ignored
    inv_a = 1;
    start_a = 1; step(); start_a = 0;
    check("inv_done_clr", 32'(done_a), 0);
    check("inv_sig_clr", 32'(sig_a), 0);
    check("inv_n0", 32'(n_a), 0);
    step();
    check("inv_r0_pat", 32'(pat_a), 0);
    check("inv_r0_resp", 32'(resp_a), 1);
    start_a = 1; step(); start_a = 0;
    check("inv_sig_mid", 32'(sig_a), 16'h0001);
    check("inv_n1_ign", 32'(n_a), 1);
    step();
    check("inv_r1_pat", 32'(pat_a), 1);
    check("inv_r1_resp", 32'(resp_a), 0);
    check("inv_busy_pre", 32'(busy_a), 1);
    check("inv_done_pre", 32'(done_a), 0);
    step();
    check("inv_done", 32'(done_a), 1);
    check("inv_busy_end", 32'(busy_a), 0);
    check("inv_sig", 32'(sig_a), 16'h0002);

    // Backpressure on the first record of an inverter sweep
    ready_a = 0;
    start_a = 1; step(); start_a = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(valid_a), 1);
      check("bp_n", 32'(n_a), 0);
      check("bp_resp", 32'(resp_a), 1);
      check("bp_sig", 32'(sig_a), 0);
      step();
    end
    check("bp_valid_last", 32'(valid_a), 1);
    ready_a = 1;
    step();
    check("bp_hs_valid", 32'(valid_a), 0);
    check("bp_hs_sig", 32'(sig_a), 16'h0001);
    check("bp_hs_n", 32'(n_a), 1);
    step();
    check("bp_r1_resp", 32'(resp_a), 0);
    step();
    check("bp_done", 32'(done_a), 1);
    check("bp_sig", 32'(sig_a), 16'h0002);

    // Instance B: N_WIDTH=2, SETTLE=3, buffer DUT
    start_b = 1; step(); start_b = 0;
    for (int p = 0; p < 4; p++) begin
      step();
      check("b_settle_valid", 32'(valid_b), 0);
      check("b_settle_n", 32'(n_b), 32'(p));
      step();
      check("b_settle_valid2", 32'(valid_b), 0);
      step();
      check("b_rec_valid", 32'(valid_b), 1);
      check("b_rec_pat", 32'(pat_b), 32'(p));
      check("b_rec_resp", 32'(resp_b), 32'(p));
      check("b_done_pre", 32'(done_b), 0);
      step();
    end
    check("b_done", 32'(done_b), 1);
    check("b_busy_end", 32'(busy_b), 0);
    check("b_sig", 32'(sig_b), 16'h0003);

    // Asynchronous reset during SETTLE of pattern 1
    start_a = 1; step(); start_a = 0;
    step(); step();
    check("ar_n_pre", 32'(n_a), 1);
    check("ar_sig_pre", 32'(sig_a), 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("ar_n", 32'(n_a), 0);
    check("ar_valid", 32'(valid_a), 0);
    check("ar_busy", 32'(busy_a), 0);
    check("ar_sig", 32'(sig_a), 0);
    check("ar_done_b", 32'(done_b), 0);
    step();
    reset = 1'b0;
    step(); step();
    check("ar_idle_valid", 32'(valid_a), 0);
    check("ar_idle_busy", 32'(busy_a), 0);
    start_a = 1; step(); start_a = 0;
    step();
    check("rs_r0_pat", 32'(pat_a), 0);
    check("rs_r0_resp", 32'(resp_a), 1);
    step(); step();
    check("rs_r1_pat", 32'(pat_a), 1);
    step();
    check("rs_done", 32'(done_a), 1);
    check("rs_sig", 32'(sig_a), 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
